// File: rtl/bit_serial_addsub_if.sv
// Handshake/operand bundle for the bit-serial adder/subtractor.
// master: the requester driving start and operands; slave: the datapath.
// Result fields are produced by the slave and held until its next done pulse.
interface bit_serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, a, b, ci, sub,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, a, b, ci, sub,
    output busy, done, s, co, ovf
  );
endinterface

// File: rtl/bit_serial_addsub.sv
// Bit-serial add/sub: a single full-adder cell walks a WIDTH-bit operand pair LSB-first.
// Latency: WIDTH cycles from the start edge to done; back-to-back throughput one op per WIDTH+1 cycles.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while busy.
// Optional signed-overflow flag enabled by defining SERIAL_ADDSUB_OVF_EN (else ovf is tied 0).
module bit_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serial_addsub_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;     // sum bits produced so far, entering from the MSB side
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             r_ovf;
`endif

  logic             w_sum;
  logic             w_cout;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // One full-adder cell fed by the LSBs of the operand shifters and the carry flop.
  assign w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_cout     = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  // Result after this cycle's bit is inserted; on the final bit this is the full result.
  assign w_res_next = {w_sum, r_res};
  // Requests are accepted only when no operation is in flight.
  assign w_load     = bus.start && (r_state != RUN);
  assign w_last     = (r_cnt == LAST);

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.s    = r_s;
  assign bus.co   = r_co;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign bus.ovf  = r_ovf;
`else
  assign bus.ovf  = 1'b0;
`endif

  // Control FSM plus serial datapath; busy/done and result flags are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_load) begin
      // Subtraction is a + ~b + ~ci, so invert B and the borrow at load time.
      r_state <= RUN;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub ? ~bus.ci : bus.ci;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_res   <= w_res_next[WIDTH-1:1];
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_s     <= w_res_next;
            r_co    <= w_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
            // r_carry is the carry into the MSB during the final bit.
            r_ovf   <= r_carry ^ w_cout;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Directed and random checks of bit_serial_addsub at WIDTH 4, 8 and 32.
// Expected results come from hand-computed tables or an arithmetic reference.
// ovf expectations follow SERIAL_ADDSUB_OVF_EN.
module tb_bit_serial_addsub;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  bit_serial_addsub_if #(.WIDTH(4))  if4 ();
  bit_serial_addsub_if #(.WIDTH(8))  if8 ();
  bit_serial_addsub_if #(.WIDTH(32)) if32 ();

  bit_serial_addsub #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  bit_serial_addsub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  bit_serial_addsub #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  // lat = negedges between the start edge and the first observed done (bounded).
  task automatic run4(input logic [3:0] a, b, input logic ci, sub,
                      output logic [3:0] s, output logic co, ovf, output int lat);
    @(negedge clk);
    if4.start = 1'b1; if4.a = a; if4.b = b; if4.ci = ci; if4.sub = sub;
    @(negedge clk);
    if4.start = 1'b0;
    lat = 0;
    while (!if4.done && lat < 40) begin @(negedge clk); lat++; end
    s = if4.s; co = if4.co; ovf = if4.ovf;
  endtask

  task automatic run8(input logic [7:0] a, b, input logic ci, sub,
                      output logic [7:0] s, output logic co, ovf, output int lat);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.ci = ci; if8.sub = sub;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 40) begin @(negedge clk); lat++; end
    s = if8.s; co = if8.co; ovf = if8.ovf;
  endtask

  task automatic run32(input logic [31:0] a, b, input logic ci, sub,
                       output logic [31:0] s, output logic co, ovf, output int lat);
    @(negedge clk);
    if32.start = 1'b1; if32.a = a; if32.b = b; if32.ci = ci; if32.sub = sub;
    @(negedge clk);
    if32.start = 1'b0;
    lat = 0;
    while (!if32.done && lat < 60) begin @(negedge clk); lat++; end
    s = if32.s; co = if32.co; ovf = if32.ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if4.busy, if4.done, if4.s, if4.co, if4.ovf} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_w4 got busy=%b done=%b s=%b co=%b ovf=%b want all 0",
               if4.busy, if4.done, if4.s, if4.co, if4.ovf);
    end
    n_tests++;
    if ({if32.busy, if32.done, if32.s, if32.co, if32.ovf} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_w32 got busy=%b done=%b s=%h want all 0", if32.busy, if32.done, if32.s);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Rows: a, b, ci, sub, expected s, co, ovf (ovf only meaningful with the feature on).
  task automatic test_vectors4(input string name, input logic [3:0] va[], input logic [3:0] vb[],
                               input logic vci[], input logic vsub[], input logic [3:0] es[],
                               input logic eco[], input logic eovf[]);
    logic [3:0] s; logic co, ovf; int lat;
    for (int i = 0; i < va.size(); i++) begin
      run4(va[i], vb[i], vci[i], vsub[i], s, co, ovf, lat);
      n_tests++;
      if (s !== es[i]) begin
        n_fail++; $display("FAIL %s[%0d] s got %b want %b", name, i, s, es[i]);
      end
      n_tests++;
      if (co !== eco[i]) begin
        n_fail++; $display("FAIL %s[%0d] co got %b want %b", name, i, co, eco[i]);
      end
      n_tests++;
      if (ovf !== (eovf[i] & OVF_EN)) begin
        n_fail++; $display("FAIL %s[%0d] ovf got %b want %b", name, i, ovf, eovf[i] & OVF_EN);
      end
      n_tests++;
      if (lat != 4) begin
        n_fail++; $display("FAIL %s[%0d] latency got %0d want 4", name, i, lat);
      end
    end
  endtask

  task automatic test_add();
    test_vectors4("add", '{4'b0000, 4'b0000, 4'b1111, 4'b1111}, '{4'b0000, 4'b0000, 4'b1111, 4'b1111},
                  '{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b0},
                  '{4'b0000, 4'b0001, 4'b1110, 4'b1111}, '{1'b0, 1'b0, 1'b1, 1'b1},
                  '{1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_sub();
    test_vectors4("sub", '{4'b0101, 4'b0011, 4'b0101}, '{4'b0011, 4'b0101, 4'b0011},
                  '{1'b0, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b1},
                  '{4'b0010, 4'b1110, 4'b0001}, '{1'b1, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_ovf();
    test_vectors4("ovf", '{4'b0111, 4'b1000, 4'b0011}, '{4'b0001, 4'b0001, 4'b0001},
                  '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0},
                  '{4'b1000, 4'b0111, 4'b0100}, '{1'b0, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0});
  endtask

  // A second start 2 cycles into RUN must not disturb the in-flight op nor queue another.
  task automatic test_ignore_start();
    int lat; int extra;
    @(negedge clk);
    if4.start = 1'b1; if4.a = 4'b0101; if4.b = 4'b0011; if4.ci = 1'b0; if4.sub = 1'b0;
    @(negedge clk);
    if4.start = 1'b0;
    lat = 0;
    while (!if4.done && lat < 40) begin
      @(negedge clk); lat++;
      if (lat == 2) begin
        if4.start = 1'b1; if4.a = 4'b1111; if4.b = 4'b1111; if4.sub = 1'b1; if4.ci = 1'b1;
      end else begin
        if4.start = 1'b0;
      end
    end
    n_tests++;
    if (lat != 4) begin n_fail++; $display("FAIL ignore latency got %0d want 4", lat); end
    n_tests++;
    if ({if4.co, if4.s} !== 5'b01000) begin
      n_fail++; $display("FAIL ignore result got co=%b s=%b want co=0 s=1000", if4.co, if4.s);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (if4.done || if4.busy) extra++;
    end
    n_tests++;
    if (extra != 0) begin n_fail++; $display("FAIL ignore stray activity got %0d cycles want 0", extra); end
  endtask

  // start asserted while done is high launches the next op on the very next edge.
  task automatic test_back_to_back();
    logic [3:0] s; logic co, ovf; int lat;
    run4(4'b0011, 4'b0001, 1'b0, 1'b0, s, co, ovf, lat);
    n_tests++;
    if (if4.done !== 1'b1 || s !== 4'b0100) begin
      n_fail++; $display("FAIL b2b first got done=%b s=%b want done=1 s=0100", if4.done, s);
    end
    if4.start = 1'b1; if4.a = 4'b0101; if4.b = 4'b0011; if4.ci = 1'b0; if4.sub = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    n_tests++;
    if (if4.busy !== 1'b1 || if4.done !== 1'b0) begin
      n_fail++; $display("FAIL b2b busy_next got busy=%b done=%b want busy=1 done=0", if4.busy, if4.done);
    end
    n_tests++;
    if (if4.s !== 4'b0100) begin n_fail++; $display("FAIL b2b held_s got %b want 0100", if4.s); end
    lat = 0;
    while (!if4.done && lat < 40) begin @(negedge clk); lat++; end
    n_tests++;
    if (lat != 4) begin n_fail++; $display("FAIL b2b latency got %0d want 4", lat); end
    n_tests++;
    if ({if4.co, if4.s} !== 5'b10010) begin
      n_fail++; $display("FAIL b2b second got co=%b s=%b want co=1 s=0010", if4.co, if4.s);
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] s; logic co, ovf; int lat; int dones;
    run8(8'h5A, 8'h33, 1'b0, 1'b0, s, co, ovf, lat);
    n_tests++;
    if ({co, s, ovf} !== {1'b0, 8'h8D, OVF_EN}) begin
      n_fail++; $display("FAIL midrst pre got co=%b s=%h ovf=%b want co=0 s=8d ovf=%b", co, s, ovf, OVF_EN);
    end
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h0F; if8.b = 8'h01; if8.ci = 1'b1; if8.sub = 1'b0;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({if8.busy, if8.done, if8.s, if8.co, if8.ovf} !== 12'h000) begin
      n_fail++; $display("FAIL midrst async got busy=%b done=%b s=%h co=%b ovf=%b want all 0",
                         if8.busy, if8.done, if8.s, if8.co, if8.ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin @(negedge clk); if (if8.done || if8.busy) dones++; end
    n_tests++;
    if (dones != 0) begin n_fail++; $display("FAIL midrst no_done got %0d active cycles want 0", dones); end
    run8(8'h0F, 8'h01, 1'b1, 1'b0, s, co, ovf, lat);
    n_tests++;
    if ({co, s, ovf} !== {1'b0, 8'h11, 1'b0} || lat != 8) begin
      n_fail++; $display("FAIL midrst fresh got co=%b s=%h ovf=%b lat=%0d want co=0 s=11 ovf=0 lat=8",
                         co, s, ovf, lat);
    end
  endtask

  task automatic test_random32();
    logic [31:0] a, b, bb, s; logic ci, sub, cc, co, ovf, e_ovf; logic [32:0] full; int lat;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom(); b = $urandom();
      ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      bb = sub ? ~b : b;
      cc = sub ? ~ci : ci;
      full = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
      e_ovf = OVF_EN & (a[31] == bb[31]) & (full[31] != a[31]);
      run32(a, b, ci, sub, s, co, ovf, lat);
      n_tests++;
      if (s !== full[31:0]) begin
        n_fail++; $display("FAIL rand32[%0d] s got %h want %h", i, s, full[31:0]);
      end
      n_tests++;
      if (co !== full[32]) begin
        n_fail++; $display("FAIL rand32[%0d] co got %b want %b", i, co, full[32]);
      end
      n_tests++;
      if (ovf !== e_ovf) begin
        n_fail++; $display("FAIL rand32[%0d] ovf got %b want %b", i, ovf, e_ovf);
      end
      n_tests++;
      if (lat != 32) begin
        n_fail++; $display("FAIL rand32[%0d] latency got %0d want 32", i, lat);
      end
    end
  endtask

  initial begin
    if4.start = 1'b0;  if4.a = '0;  if4.b = '0;  if4.ci = 1'b0;  if4.sub = 1'b0;
    if8.start = 1'b0;  if8.a = '0;  if8.b = '0;  if8.ci = 1'b0;  if8.sub = 1'b0;
    if32.start = 1'b0; if32.a = '0; if32.b = '0; if32.ci = 1'b0; if32.sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ovf();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_random32();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
